sfx_sequencer: RTL and testbench

Sound-effect sequencer that drives the board's single-bit `audio_left` pin. It sits downstream of the game-state logic, in the top level next to the player and ball modules. It watches the game-state levels `start`, `fight`, `caught` and `ending`. A rising edge on any of them plays a short fixed melody from an internal note ROM as a 50 %-duty square wave.

---
 rtl/sfx_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_sfx_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: edge-triggered, priority-preemptive playback of short
// square-wave melodies from a fixed note ROM onto a single audio pin.
module sfx_sequencer #(
  parameter int unsigned TICK_DIV    = 100_000,
  parameter int unsigned HP_OVERRIDE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       fight,
  input  logic       caught,
  input  logic       ending,
  input  logic       mute,
  output logic       audio_left,
  output logic       busy,
  output logic [1:0] sfx_id
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t        state_q, state_d;
  logic [3:0]    lvl, prev_q, trig;
  logic [1:0]    sel_id, id_q, id_d, idx_q, idx_d;
  logic          sel_valid;
  logic [16:0]   hp_q, hp_d, tone_q, tone_d, rom_hp;
  logic [9:0]    dur_q, dur_d, dcnt_q, dcnt_d, rom_dur;
  logic [TW-1:0] tick_q, tick_d;
  logic          wave_q, wave_d, audio_d;

  // Bit position equals the effect id: 0 START, 1 FIGHT, 2 CAUGHT, 3 ENDING.
  assign lvl       = {ending, caught, fight, start};
  assign trig      = lvl & ~prev_q;
  assign sel_valid = |trig;

  function automatic logic [1:0] rank(input logic [1:0] id);
    case (id)
      2'd2:    return 2'd3;
      2'd1:    return 2'd2;
      2'd3:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [26:0] rom(input logic [3:0] addr);
    logic [16:0] hp;
    logic [9:0]  d;
    case (addr)
      4'h0:    begin hp = 17'd95602;  d = 10'd120; end
      4'h1:    begin hp = 17'd75873;  d = 10'd120; end
      4'h2:    begin hp = 17'd63776;  d = 10'd240; end
      4'h4:    begin hp = 17'd113636; d = 10'd80;  end
      4'h5:    begin hp = 17'd0;      d = 10'd40;  end
      4'h6:    begin hp = 17'd113636; d = 10'd80;  end
      4'h7:    begin hp = 17'd75873;  d = 10'd200; end
      4'h8:    begin hp = 17'd63776;  d = 10'd100; end
      4'h9:    begin hp = 17'd47755;  d = 10'd100; end
      4'hA:    begin hp = 17'd0;      d = 10'd50;  end
      4'hB:    begin hp = 17'd47755;  d = 10'd300; end
      4'hC:    begin hp = 17'd95602;  d = 10'd200; end
      4'hD:    begin hp = 17'd127551; d = 10'd200; end
      4'hE:    begin hp = 17'd95602;  d = 10'd400; end
      default: begin hp = '0;         d = '0;      end
    endcase
    if (HP_OVERRIDE != 0 && hp != '0) hp = 17'(HP_OVERRIDE);
    return {hp, d};
  endfunction

  always_comb begin
    sel_id = 2'd0;
    if (trig[2])      sel_id = 2'd2;
    else if (trig[1]) sel_id = 2'd1;
    else if (trig[3]) sel_id = 2'd3;
  end

  assign {rom_hp, rom_dur} = rom({id_q, idx_q});

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    idx_d   = idx_q;
    hp_d    = hp_q;
    dur_d   = dur_q;
    tone_d  = tone_q;
    tick_d  = tick_q;
    dcnt_d  = dcnt_q;
    wave_d  = wave_q;
    case (state_q)
      IDLE: begin
        wave_d = 1'b0;
        if (sel_valid) begin
          id_d    = sel_id;
          idx_d   = 2'd0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (rom_dur == '0) begin
          state_d = IDLE;
        end else begin
          hp_d    = rom_hp;
          dur_d   = rom_dur;
          tone_d  = '0;
          tick_d  = '0;
          dcnt_d  = '0;
          wave_d  = 1'b0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (hp_q == '0) begin
          wave_d = 1'b0;
          tone_d = '0;
        end else if (tone_q == hp_q - 17'd1) begin
          wave_d = ~wave_q;
          tone_d = '0;
        end else begin
          tone_d = tone_q + 17'd1;
        end
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          dcnt_d = dcnt_q + 10'd1;
          if (dcnt_q + 10'd1 == dur_q) begin
            // Every LOAD cycle is silent: wave is cleared on the way in.
            wave_d = 1'b0;
            if (idx_q == 2'd3) begin
              state_d = IDLE;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = LOAD;
            end
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && sel_valid && rank(sel_id) > rank(id_q)) begin
      id_d    = sel_id;
      idx_d   = 2'd0;
      wave_d  = 1'b0;
      state_d = LOAD;
    end
    audio_d = wave_d & ~mute & (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    prev_q <= lvl;
    if (reset) begin
      state_q    <= IDLE;
      id_q       <= '0;
      idx_q      <= '0;
      hp_q       <= '0;
      dur_q      <= '0;
      tone_q     <= '0;
      tick_q     <= '0;
      dcnt_q     <= '0;
      wave_q     <= 1'b0;
      audio_left <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      idx_q      <= idx_d;
      hp_q       <= hp_d;
      dur_q      <= dur_d;
      tone_q     <= tone_d;
      tick_q     <= tick_d;
      dcnt_q     <= dcnt_d;
      wave_q     <= wave_d;
      audio_left <= audio_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign sfx_id = id_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: directed scenarios plus random triggering, checked
// every cycle against a schedule-based reference model of the effects.
module tb_sfx_sequencer;

  localparam int TD = 10;

  logic       clk = 1'b0;
  logic       reset, start, fight, caught, ending, mute;
  logic       audio_a, busy_a, audio_b, busy_b;
  logic [1:0] id_a, id_b;

  always #5 clk = ~clk;

  sfx_sequencer #(.TICK_DIV(TD)) dut_a (
    .clk(clk), .reset(reset), .start(start), .fight(fight), .caught(caught),
    .ending(ending), .mute(mute), .audio_left(audio_a), .busy(busy_a), .sfx_id(id_a)
  );

  sfx_sequencer #(.TICK_DIV(TD), .HP_OVERRIDE(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .fight(fight), .caught(caught),
    .ending(ending), .mute(mute), .audio_left(audio_b), .busy(busy_b), .sfx_id(id_b)
  );

  int hp_tab [16];
  int dur_tab [16];

  int n_checks = 0;
  int n_fail   = 0;

  int         t = 0;
  logic [3:0] m_prev = '0;
  int         cur_id = 0;
  int         t_start = 0;
  bit         active = 0;
  bit         period_armed = 0;
  int         last_rise = -1;
  bit         audio_b_prev = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, t, got, exp);
    end
  endtask

  function automatic int prio(input int id);
    case (id)
      2:       return 3;
      1:       return 2;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  // e = cycles since the effect's first LOAD cycle; returns busy and wave level.
  function automatic void note_model(input int id, input int e, input bit ovr,
                                     output bit b, output bit w);
    int pos, hp, d, len;
    b = 0; w = 0; pos = 0;
    if (e < 0) return;
    for (int k = 0; k < 4; k++) begin
      hp = hp_tab[id*4+k];
      d  = dur_tab[id*4+k];
      if (ovr && hp != 0) hp = 4;
      if (e == pos) begin b = 1; return; end
      if (d == 0) return;
      pos++;
      len = d * TD;
      if (e < pos + len) begin
        b = 1;
        if (hp != 0) w = (((e - pos) / hp) % 2) == 1;
        return;
      end
      pos += len;
    end
  endfunction

  task automatic step();
    logic [3:0] lv, trig;
    bit rs, mt, was, wx, bb, wa, wb;
    int sel;
    lv = {ending, caught, fight, start};
    rs = reset;
    mt = mute;
    @(posedge clk);
    t++;
    if (rs) begin
      m_prev = lv; active = 0; cur_id = 0;
    end else begin
      trig   = lv & ~m_prev;
      m_prev = lv;
      was = 0; wx = 0;
      if (active) note_model(cur_id, t - 1 - t_start, 0, was, wx);
      if (trig != '0) begin
        sel = -1;
        for (int i = 0; i < 4; i++)
          if (trig[i] && (sel < 0 || prio(i) > prio(sel))) sel = i;
        if (!was || prio(sel) > prio(cur_id)) begin
          cur_id = sel; t_start = t; active = 1;
        end
      end
    end
    bb = 0; wa = 0; wb = 0;
    if (active) begin
      note_model(cur_id, t - t_start, 0, bb, wa);
      note_model(cur_id, t - t_start, 1, bb, wb);
    end
    @(negedge clk);
    check("busy_a",   busy_a,  bb);
    check("busy_b",   busy_b,  bb);
    check("audio_a",  audio_a, bb & wa & ~mt);
    check("audio_b",  audio_b, bb & wb & ~mt);
    check("sfx_id_a", id_a,    cur_id);
    check("sfx_id_b", id_b,    cur_id);
    if (period_armed && audio_b && !audio_b_prev) begin
      if (last_rise >= 0) begin
        check("b_period", t - last_rise, 8);
        period_armed = 0;
      end
      last_rise = t;
    end
    audio_b_prev = audio_b;
  endtask

  task automatic run_effect(input int budget, output int len);
    len = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (busy_a) len++;
      else if (len > 0) break;
    end
  endtask

  task automatic all_low();
    start = 0; fight = 0; caught = 0; ending = 0;
    repeat (3) step();
  endtask

  int len;

  initial begin
    hp_tab  = '{95602, 75873, 63776, 0, 113636, 0, 113636, 75873,
                63776, 47755, 0, 47755, 95602, 127551, 95602, 0};
    dur_tab = '{120, 120, 240, 0, 80, 40, 80, 200,
                100, 100, 50, 300, 200, 200, 400, 0};

    reset = 1; start = 0; fight = 1; caught = 0; ending = 0; mute = 0;
    repeat (5) step();
    reset = 0;
    repeat (100) step();
    all_low();

    repeat ($urandom_range(1, 20)) step();
    start = 1;
    run_effect(6000, len);
    check("start_len", len, 4804);
    check("start_id", id_a, 0);
    all_low();

    period_armed = 1; last_rise = -1;
    fight = 1;
    run_effect(6000, len);
    check("fight_len", len, 4004);
    check("b_period_seen", period_armed, 0);
    all_low();

    fight = 1;
    repeat (500) step();
    caught = 1;
    repeat (2) step();
    check("preempt_id", id_a, 2);
    repeat (300) step();
    start = 1;
    repeat (2) step();
    check("start_ignored_id", id_a, 2);
    run_effect(7000, len);
    check("caught_done", busy_a, 0);
    all_low();

    start = 1; fight = 1; ending = 1;
    repeat (2) step();
    check("simul_id", id_a, 1);
    run_effect(6000, len);
    all_low();

    ending = 1;
    for (int i = 0; i < 1500; i++) begin
      mute = (i > 200 && i < 900) ? 1'b1 : 1'(($urandom_range(0, 3) == 0));
      step();
    end
    mute = 0;
    reset = 1;
    step();
    check("reset_busy", busy_a, 0);
    check("reset_audio_b", audio_b, 0);
    reset = 0;
    all_low();

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0: start  = ~start;
        1: fight  = ~fight;
        2: caught = ~caught;
        3: ending = ~ending;
        default: ;
      endcase
      mute  = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) == 0);
      repeat ($urandom_range(1, 100)) step();
      reset = 0;
    end
    mute = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
